// File: rtl/sp_ram_banked_arb.sv
// Multi-port, word-interleaved, multi-bank single-port RAM with a round-robin arbiter
// per bank and a global write bypass. Grants are combinational; responses arrive one cycle later.
module sp_ram_banked_arb #(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   rstn_i,
    input  logic [NUM_PORTS-1:0]                   req_i,
    output logic [NUM_PORTS-1:0]                   gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]                   we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]                   rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
    input  logic                                   bypass_en_i
);

    localparam int BANK_LOG = $clog2(NUM_BANKS);
    localparam int BANK_W   = (BANK_LOG > 0) ? BANK_LOG : 1;
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int ROW_W    = ADDR_WIDTH - 2 - BANK_LOG;
    localparam int DEPTH    = 1 << ROW_W;
    localparam int NBYTES   = DATA_WIDTH / 8;

    function automatic int wrap_port(input int base, input int off);
        return (base + off) % NUM_PORTS;
    endfunction

    logic [NUM_PORTS-1:0][BANK_W-1:0]     w_port_bank;
    logic [NUM_PORTS-1:0][ROW_W-1:0]      w_port_row;
    logic [NUM_PORTS-1:0][1:0]            w_unused_addr_lsb;
    logic [NUM_BANKS-1:0]                 w_bank_gnt;
    logic [NUM_BANKS-1:0][PORT_W-1:0]     w_bank_win;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;
    logic [NUM_BANKS-1:0][PORT_W-1:0]     r_rr;
    logic [NUM_PORTS-1:0]                 r_rvalid;
    logic [NUM_PORTS-1:0]                 r_is_read;
    logic [NUM_PORTS-1:0][BANK_W-1:0]     r_src_bank;

    // Word-interleaved decode: the bank field sits just above the byte offset.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_decode
        assign w_port_row[p]        = addr_i[p][ADDR_WIDTH-1 -: ROW_W];
        assign w_unused_addr_lsb[p] = addr_i[p][1:0];
        if (BANK_LOG > 0) begin : g_bank_field
            assign w_port_bank[p] = addr_i[p][2 +: BANK_W];
        end else begin : g_single_bank
            assign w_port_bank[p] = '0;
        end
    end

    // NOTE: blocking assignments with defaults first keep this block latch-free and
    // let w_bank_gnt act as the "winner already found" flag during the search.
    always_comb begin
        w_bank_gnt = '0;
        w_bank_win = '0;
        gnt_o      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!w_bank_gnt[b] && req_i[wrap_port(int'(r_rr[b]), k)] &&
                    int'(w_port_bank[wrap_port(int'(r_rr[b]), k)]) == b) begin
                    w_bank_gnt[b]                      = 1'b1;
                    w_bank_win[b]                      = PORT_W'(wrap_port(int'(r_rr[b]), k));
                    gnt_o[wrap_port(int'(r_rr[b]), k)] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rr <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_gnt[b]) begin
                    r_rr[b] <= PORT_W'(wrap_port(int'(w_bank_win[b]), 1));
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_rdata;
        logic [PORT_W-1:0]     w_win;
        logic [ROW_W-1:0]      w_row;

        assign w_win           = w_bank_win[b];
        assign w_row           = w_port_row[w_win];
        assign w_bank_rdata[b] = r_rdata;

        // NOTE: the array and its read register have no reset so they map onto SRAM macros;
        // the response path is gated by the reset rvalid flops instead.
        always_ff @(posedge clk) begin
            if (w_bank_gnt[b]) begin
                if (we_i[w_win]) begin
                    if (!bypass_en_i) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (be_i[w_win][i]) begin
                                r_mem[w_row][8*i +: 8] <= wdata_i[w_win][8*i +: 8];
                            end
                        end
                    end
                end else begin
                    r_rdata <= r_mem[w_row];
                end
            end
        end
    end

    // Response tracking per port; reset drops anything in flight.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rvalid   <= '0;
            r_is_read  <= '0;
            r_src_bank <= '0;
        end else begin
            r_rvalid   <= gnt_o;
            r_is_read  <= gnt_o & ~we_i;
            r_src_bank <= w_port_bank;
        end
    end

    assign rvalid_o = r_rvalid;

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_rvalid[p] && r_is_read[p]) begin
                rdata_o[p] = w_bank_rdata[r_src_bank[p]];
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_banked_arb.sv
// Directed bench for sp_ram_banked_arb: stimulus checks grants and queues expected
// responses; a negedge monitor matches every rvalid against the queue.
module tb_sp_ram_banked_arb;

    localparam int AW = 15;

    logic               clk = 1'b0;
    logic               rstn_i;
    logic [1:0]         req_i;
    logic [1:0]         gnt_o;
    logic [1:0][AW-1:0] addr_i;
    logic [1:0]         we_i;
    logic [1:0][3:0]    be_i;
    logic [1:0][31:0]   wdata_i;
    logic [1:0]         rvalid_o;
    logic [1:0][31:0]   rdata_o;
    logic               bypass_en_i;

    sp_ram_banked_arb dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .bypass_en_i (bypass_en_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t sb [2][$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the oldest expectation due in this cycle.
    always @(negedge clk) begin
        if (rstn_i) begin
            for (int p = 0; p < 2; p++) begin
                if (rvalid_o[p]) begin
                    if (sb[p].size() == 0 || sb[p][0].due != cyc) begin
                        check($sformatf("unexpected_rvalid_p%0d", p), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("rdata_p%0d", p), 64'(rdata_o[p]), 64'(sb[p][0].data));
                        void'(sb[p].pop_front());
                    end
                end else if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
                    check($sformatf("missing_rvalid_p%0d", p), 64'd0, 64'd1);
                    void'(sb[p].pop_front());
                end
            end
        end
    end

    task automatic idle();
        req_i   = '0;
        we_i    = '0;
        be_i    = '0;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic drive(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        req_i[p]   = 1'b1;
        we_i[p]    = we;
        addr_i[p]  = a;
        be_i[p]    = be;
        wdata_i[p] = d;
    endtask

    // Check grant, queue the expected responses, then advance one cycle.
    task automatic step(input string name, input logic [1:0] exp_gnt,
                        input logic [31:0] d0, input logic [31:0] d1);
        #1;
        check(name, 64'(gnt_o), 64'(exp_gnt));
        if (exp_gnt[0]) sb[0].push_back('{cyc + 1, d0});
        if (exp_gnt[1]) sb[1].push_back('{cyc + 1, d1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn_i      = 1'b0;
        bypass_en_i = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        req_i = 2'b01;
        #1;
        check("rst_gnt_follows_req", 64'(gnt_o), 64'd1);
        check("rst_rvalid", 64'(rvalid_o), 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        idle();
        rstn_i = 1'b1;
        @(posedge clk);
        #1;

        // One word per bank, then read back.
        for (int i = 0; i < 4; i++) begin
            idle();
            drive(0, 1'b1, AW'(4 * i), 4'hF, 32'hDEADBEEF);
            step("wr_gnt", 2'b01, 32'h0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            drive(0, 1'b0, AW'(4 * i), 4'h0, 32'h0);
            step("rd_gnt", 2'b01, 32'hDEADBEEF, 32'h0);
        end

        // Byte enables, with read-after-write in consecutive cycles.
        idle(); drive(0, 1'b1, AW'('h10), 4'hF, 32'h11223344);
        step("be_wr1_gnt", 2'b01, 32'h0, 32'h0);
        idle(); drive(0, 1'b1, AW'('h10), 4'b0101, 32'hAABBCCDD);
        step("be_wr2_gnt", 2'b01, 32'h0, 32'h0);
        idle(); drive(0, 1'b0, AW'('h10), 4'h0, 32'h0);
        step("be_rd_gnt", 2'b01, 32'h11BB33DD, 32'h0);

        // Port 1 seeds 0x20 (bank 0 pointer returns to 0), then both ports contend.
        idle(); drive(1, 1'b1, AW'('h20), 4'hF, 32'h5A5A0020);
        step("seed_gnt", 2'b10, 32'h0, 32'h0);
        idle();
        drive(0, 1'b0, AW'('h20), 4'h0, 32'h0);
        drive(1, 1'b0, AW'('h20), 4'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("contend_gnt_%0d", i), (i % 2 == 0) ? 2'b01 : 2'b10,
                 32'h5A5A0020, 32'h5A5A0020);
        end

        // Different banks in the same cycle.
        idle();
        drive(0, 1'b0, AW'('h0), 4'h0, 32'h0);
        drive(1, 1'b0, AW'('h4), 4'h0, 32'h0);
        step("no_conflict_gnt", 2'b11, 32'hDEADBEEF, 32'hDEADBEEF);

        // Bypass: the second write is acknowledged but not committed; reads ignore bypass.
        idle(); drive(0, 1'b1, AW'('h40), 4'hF, 32'hCAFEF00D);
        step("byp_wr_gnt", 2'b01, 32'h0, 32'h0);
        idle(); bypass_en_i = 1'b1; drive(0, 1'b1, AW'('h40), 4'hF, 32'h0);
        step("byp_skip_gnt", 2'b01, 32'h0, 32'h0);
        idle(); drive(0, 1'b0, AW'('h40), 4'h0, 32'h0);
        step("byp_rd_gnt", 2'b01, 32'hCAFEF00D, 32'h0);
        idle(); bypass_en_i = 1'b0; drive(1, 1'b0, AW'('h40), 4'h0, 32'h0);
        step("byp_rd_p1_gnt", 2'b10, 32'h0, 32'hCAFEF00D);

        // Reset right after a read is accepted: its response must never appear.
        idle(); drive(0, 1'b0, AW'('h0), 4'h0, 32'h0);
        #1;
        check("pre_rst_gnt", 64'(gnt_o), 64'd1);
        @(posedge clk);
        #1;
        rstn_i = 1'b0;
        idle();
        #1;
        check("mid_rst_rvalid", 64'(rvalid_o), 64'd0);
        check("mid_rst_rdata", rdata_o, 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rstn_i = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 1'b0, AW'('h0), 4'h0, 32'h0);
        drive(1, 1'b0, AW'('h0), 4'h0, 32'h0);
        step("post_rst_gnt0", 2'b01, 32'hDEADBEEF, 32'hDEADBEEF);
        step("post_rst_gnt1", 2'b10, 32'hDEADBEEF, 32'hDEADBEEF);
        idle();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb[0].size() + sb[1].size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_banked_arb.md
# sp_ram_banked_arb

Multi-port, multi-bank single-port-SRAM subsystem for the PULPino data memory. It replaces the single-requestor RAM wrapper with NUM_PORTS independent req/gnt/rvalid channels. These channels are word-interleaved across NUM_BANKS single-port banks, and each bank has its own round-robin arbiter. The bypass function is kept, so writes can be acknowledged without being committed.

## Interface
Parameters:
- RAM_SIZE, 32768, total capacity in bytes; must be a power of 2.
- DATA_WIDTH, 32, word width in bits; only 32 is supported.
- NUM_BANKS, 4, number of banks; power of 2, ≥1. Each bank holds RAM_SIZE/NUM_BANKS bytes.
- NUM_PORTS, 2, number of requestor channels, ≥1.
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width.

Ports (index p = 0..NUM_PORTS-1):
- clk  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset; asynchronous, active-low.
- req_i  in  NUM_PORTS  request valid, per port.
- gnt_o  out  NUM_PORTS  grant, per port; combinational from the current-cycle request.
- addr_i  in  NUM_PORTS×ADDR_WIDTH  byte address; bits [1:0] are ignored.
- we_i  in  NUM_PORTS  1 = write, 0 = read.
- be_i  in  NUM_PORTS×DATA_WIDTH/8  byte enables for writes.
- wdata_i  in  NUM_PORTS×DATA_WIDTH  write data.
- rvalid_o  out  NUM_PORTS  response valid, per port.
- rdata_o  out  NUM_PORTS×DATA_WIDTH  read data; valid only when rvalid_o is high.
- bypass_en_i  in  1  global; when high, granted writes are not committed.

## Operation
- Bank select: bank = addr_i[p][2 +: log2(NUM_BANKS)]. Row = addr_i[p][ADDR_WIDTH-1 : 2+log2(NUM_BANKS)]. With NUM_BANKS = 1 there is no bank field.
- Each bank has its own round-robin pointer rr_b (log2(NUM_PORTS) bits).
- Winner selection: the first requesting port to that bank, searching upward from rr_b and wrapping at NUM_PORTS-1 → 0.
- At most one grant per bank per cycle. Ports hitting different banks are all granted in the same cycle.
- On a grant, rr_b ← (winner+1) mod NUM_PORTS. A bank with no grant keeps rr_b.
- Granted write: bytes with be_i = 1 are updated at the edge. Bytes with be_i = 0 keep their value. When bypass_en_i = 1 at the grant edge, no bytes are written.
- Granted read: the bank performs a synchronous read of the row.
- Every grant (read or write) produces exactly one rvalid_o pulse on the same port.
  - Read response: rdata_o carries the row contents from before any write at that same edge.
  - Write response: rdata_o = 0.
- Requestor rule: once req_i is raised, addr/we/be/wdata are held stable until gnt_o is sampled high. A port may drop req_i only in a granted cycle or when it has not yet raised it.
- Bank arrays are not reset. Their contents are X until written.

## Timing
- Grant: same cycle as the request, combinational. The request is accepted at the rising edge where req_i & gnt_o is high.
- Response latency: exactly 1 cycle. rvalid_o[p] is high in the cycle after acceptance and lasts 1 cycle. rdata_o is registered.
- Back-to-back: a port granted every cycle receives rvalid every cycle, with full throughput and no bubbles.
- Contention: with K ports hammering one bank, each port is granted once every K cycles. Worst-case wait is NUM_PORTS-1 cycles.
- Read-after-write to the same word, from any port in consecutive cycles: the read returns the new data.
- Reset values: gnt_o follows req_i combinationally (it is not forced low during reset). rvalid_o = 0, rdata_o = 0, all rr_b = 0.
- Reset mid-operation: responses already in flight are dropped, and no rvalid_o appears after rstn_i rises for a pre-reset grant. A write accepted at an edge before reset asserted has already been committed.
- bypass_en_i is sampled only at grant edges. Toggling it never affects reads.

## Test plan
- Single port, all banks: write 0xDEADBEEF at 0x0, 0x4, 0x8, 0xC with be = 0xF, then read each back. Expect gnt in the same cycle, rvalid 1 cycle later, data matches; write rvalids carry rdata = 0.
- Byte enables: write 0x11223344 at 0x10, then write 0xAABBCCDD with be = 0b0101, then read. Expect 0x11BB33DD.
- Conflict and fairness: NUM_PORTS = 2, both ports continuously read 0x20 for 6 cycles. Expect grants alternating p0, p1, p0, …; every grant gets a single-cycle rvalid.
- No conflict: port 0 reads 0x0 while port 1 reads 0x4 in the same cycle. Expect both granted in that cycle and both rvalid in the next cycle.
- Bypass: write 0xCAFEF00D at 0x40, then write 0x0 with bypass_en_i = 1, then read. Expect the bypassed write to get gnt and rvalid, and the read to return 0xCAFEF00D.
- Reset mid-access: grant a read, then assert rstn_i low before the next edge. Expect rvalid_o and rdata_o = 0 during reset and no rvalid after release; rr_b = 0, so port 0 wins the first post-reset contention.
